// File: rtl/char_pkg.sv
// Shared state codes, screen geometry and default frame timings for the
// character sequencer, renderer and collision logic.
package char_pkg;

   // FSM state codes as seen by the renderer; 3'd7 is unused.
   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      MOVE_FWD     = 3'd1,
      MOVE_BACK    = 3'd2,
      HITSTUN      = 3'd3,
      ATK_STARTUP  = 3'd4,
      ATK_ACTIVE   = 3'd5,
      ATK_RECOVERY = 3'd6
   } char_state_t;

   localparam int unsigned SPRITE_W = 64;
   localparam int unsigned SCREEN_W = 640;

   localparam logic [4:0] DEF_STARTUP_FRAMES  = 5'd5;
   localparam logic [4:0] DEF_ACTIVE_FRAMES   = 5'd2;
   localparam logic [4:0] DEF_RECOVERY_FRAMES = 5'd16;
   localparam logic [4:0] DEF_HITSTUN_FRAMES  = 5'd12;

   // Add with an 11-bit intermediate and clamp to hi, so no wrap-around.
   function automatic logic [9:0] sat_add(input logic [9:0] x,
                                          input logic [3:0] d,
                                          input logic [9:0] hi);
      logic [10:0] s;
      s = {1'b0, x} + {7'b0, d};
      return (s > {1'b0, hi}) ? hi : s[9:0];
   endfunction

   // Subtract with an 11-bit intermediate; bit 10 flags an underflow.
   function automatic logic [9:0] sat_sub(input logic [9:0] x,
                                          input logic [3:0] d,
                                          input logic [9:0] lo);
      logic [10:0] s;
      s = {1'b0, x} - {7'b0, d};
      return (s[10] || (s < {1'b0, lo})) ? lo : s[9:0];
   endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for a raw button, plus the level seen at the
// previous frame tick so a press is reported once per frame-sampled edge.
module btn_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic frame_tick,
   input  logic btn,
   output logic level,
   output logic rise
);

   logic meta;
   logic sync;
   logic prev;

   // Bring the asynchronous button into the clk domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         sync <= 1'b0;
      end else begin
         meta <= btn;
         sync <= meta;
      end
   end

   // Remember the synced level as sampled at the last frame tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         prev <= 1'b0;
      else if (frame_tick)
         prev <= sync;
   end

   assign level = sync;
   assign rise  = sync & ~prev;

endmodule

// File: rtl/character_controller.sv
// Per-player movement / attack / hitstun sequencer, advancing once per
// video frame and feeding the sprite renderer with registered outputs.
module character_controller
   import char_pkg::*;
#(
   parameter logic [9:0] X_INIT          = 10'd100,
   parameter logic [9:0] X_MIN           = 10'd0,
   parameter logic [9:0] X_MAX           = 10'(SCREEN_W - SPRITE_W),
   parameter logic [3:0] FWD_SPEED       = 4'd3,
   parameter logic [3:0] BACK_SPEED      = 4'd2,
   parameter logic [4:0] STARTUP_FRAMES  = DEF_STARTUP_FRAMES,
   parameter logic [4:0] ACTIVE_FRAMES   = DEF_ACTIVE_FRAMES,
   parameter logic [4:0] RECOVERY_FRAMES = DEF_RECOVERY_FRAMES,
   parameter logic [4:0] HITSTUN_FRAMES  = DEF_HITSTUN_FRAMES
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_attack,
   input  logic       hit_received,
   output logic [9:0] x_pos,
   output logic [2:0] state,
   output logic       attacking,
   output logic [4:0] frame_cnt
);

   logic        left;
   logic        right;
   logic        att_edge;
   logic        hit_pend;
   logic        hit_now;
   char_state_t st;
   logic        unused_sync;
   logic        left_rise;
   logic        right_rise;
   logic        att_level;

   btn_sync u_sync_left (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_tick (frame_tick),
      .btn        (btn_left),
      .level      (left),
      .rise       (left_rise)
   );

   btn_sync u_sync_right (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_tick (frame_tick),
      .btn        (btn_right),
      .level      (right),
      .rise       (right_rise)
   );

   btn_sync u_sync_attack (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_tick (frame_tick),
      .btn        (btn_attack),
      .level      (att_level),
      .rise       (att_edge)
   );

   assign unused_sync = left_rise ^ right_rise ^ att_level;

   // A hit on the tick cycle itself is applied on that tick.
   assign hit_now = hit_pend | hit_received;

   // Hold a hit pulse until the next frame tick consumes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         hit_pend <= 1'b0;
      else if (frame_tick)
         hit_pend <= 1'b0;
      else if (hit_received)
         hit_pend <= 1'b1;
   end

   // Frame-rate FSM with registered position, state, counter and attack flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= IDLE;
         x_pos     <= X_INIT;
         frame_cnt <= '0;
         attacking <= 1'b0;
      end else if (frame_tick) begin
         if (hit_now) begin
            st        <= HITSTUN;
            frame_cnt <= '0;
            attacking <= 1'b0;
         end else begin
            case (st)
               IDLE, MOVE_FWD, MOVE_BACK: begin
                  frame_cnt <= '0;
                  if (att_edge) begin
                     st        <= ATK_STARTUP;
                     attacking <= 1'b1;
                  end else if (right && !left) begin
                     st        <= MOVE_FWD;
                     x_pos     <= sat_add(x_pos, FWD_SPEED, X_MAX);
                     attacking <= 1'b0;
                  end else if (left && !right) begin
                     st        <= MOVE_BACK;
                     x_pos     <= sat_sub(x_pos, BACK_SPEED, X_MIN);
                     attacking <= 1'b0;
                  end else begin
                     st        <= IDLE;
                     attacking <= 1'b0;
                  end
               end
               HITSTUN: begin
                  attacking <= 1'b0;
                  if (frame_cnt == HITSTUN_FRAMES - 5'd1) begin
                     st        <= IDLE;
                     frame_cnt <= '0;
                  end else begin
                     frame_cnt <= frame_cnt + 5'd1;
                  end
               end
               ATK_STARTUP: begin
                  attacking <= 1'b1;
                  if (frame_cnt == STARTUP_FRAMES - 5'd1) begin
                     st        <= ATK_ACTIVE;
                     frame_cnt <= '0;
                  end else begin
                     frame_cnt <= frame_cnt + 5'd1;
                  end
               end
               ATK_ACTIVE: begin
                  attacking <= 1'b1;
                  if (frame_cnt == ACTIVE_FRAMES - 5'd1) begin
                     st        <= ATK_RECOVERY;
                     frame_cnt <= '0;
                  end else begin
                     frame_cnt <= frame_cnt + 5'd1;
                  end
               end
               ATK_RECOVERY: begin
                  if (frame_cnt == RECOVERY_FRAMES - 5'd1) begin
                     st        <= IDLE;
                     frame_cnt <= '0;
                     attacking <= 1'b0;
                  end else begin
                     frame_cnt <= frame_cnt + 5'd1;
                     attacking <= 1'b1;
                  end
               end
               default: begin
                  st        <= IDLE;
                  frame_cnt <= '0;
                  attacking <= 1'b0;
               end
            endcase
         end
      end
   end

   assign state = st;

endmodule

// File: tb/tb_character_controller.sv
// Directed self-checking bench for character_controller.
module tb_character_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic       btn_left = 1'b0;
   logic       btn_right = 1'b0;
   logic       btn_attack = 1'b0;
   logic       hit_received = 1'b0;
   logic [9:0] x_pos;
   logic [2:0] state;
   logic       attacking;
   logic [4:0] frame_cnt;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   character_controller dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .frame_tick   (frame_tick),
      .btn_left     (btn_left),
      .btn_right    (btn_right),
      .btn_attack   (btn_attack),
      .hit_received (hit_received),
      .x_pos        (x_pos),
      .state        (state),
      .attacking    (attacking),
      .frame_cnt    (frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Three idle cycles (enough for the synchronisers), then one tick cycle.
   task automatic tick(input logic hit);
      repeat (3) @(negedge clk);
      frame_tick   = 1'b1;
      hit_received = hit;
      @(negedge clk);
      frame_tick   = 1'b0;
      hit_received = 1'b0;
   endtask

   task automatic pulse_hit();
      @(negedge clk);
      hit_received = 1'b1;
      @(negedge clk);
      hit_received = 1'b0;
   endtask

   // Assert reset between clock edges and check it takes effect at once.
   task automatic do_reset(input string tag);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check({tag, "_x"},   x_pos, 100);
      check({tag, "_st"},  state, 0);
      check({tag, "_att"}, attacking, 0);
      check({tag, "_cnt"}, frame_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   int exp_st;
   int exp_cnt;
   int att_ticks;
   int max_x;

   initial begin
      // Power-on reset
      do_reset("por");

      // Hold right for 10 ticks: 100 -> 130
      btn_right = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick(1'b0);
         check("fwd_x", x_pos, 100 + 3 * i);
      end
      check("fwd_st", state, 1);
      max_x = 0;
      for (int i = 0; i < 200; i++) begin
         tick(1'b0);
         if (x_pos > max_x) max_x = x_pos;
      end
      check("fwd_max", max_x, 576);
      check("fwd_sat_x", x_pos, 576);
      check("fwd_sat_st", state, 1);

      // Reset while moving
      do_reset("mid");
      btn_right = 1'b0;

      // 100 -> 103, then left 51 ticks -> 1, then clamp to 0
      btn_right = 1'b1;
      tick(1'b0);
      check("r1_x", x_pos, 103);
      btn_right = 1'b0;
      btn_left  = 1'b1;
      for (int i = 0; i < 51; i++) tick(1'b0);
      check("back_x1", x_pos, 1);
      check("back_st", state, 2);
      tick(1'b0);
      check("back_x0", x_pos, 0);
      check("back_st_bound", state, 2);
      tick(1'b0);
      check("back_x0_hold", x_pos, 0);
      btn_left = 1'b0;
      tick(1'b0);
      check("rel_idle", state, 0);

      // Attack pressed and held for 30 ticks
      btn_attack = 1'b1;
      att_ticks = 0;
      for (int i = 1; i <= 30; i++) begin
         tick(1'b0);
         if (i <= 5) begin exp_st = 4; exp_cnt = i - 1; end
         else if (i <= 7) begin exp_st = 5; exp_cnt = i - 6; end
         else if (i <= 23) begin exp_st = 6; exp_cnt = i - 8; end
         else begin exp_st = 0; exp_cnt = 0; end
         check("atk_st", state, exp_st);
         check("atk_cnt", frame_cnt, exp_cnt);
         check("atk_flag", attacking, (exp_st >= 4) ? 1 : 0);
         if (attacking) att_ticks++;
      end
      check("atk_ticks", att_ticks, 23);
      check("atk_x_hold", x_pos, 0);

      // Release then re-press starts a new attack
      btn_attack = 1'b0;
      tick(1'b0);
      check("rel_st", state, 0);
      btn_attack = 1'b1;
      tick(1'b0);
      check("repress_st", state, 4);
      for (int i = 2; i <= 6; i++) tick(1'b0);
      check("act1_st", state, 5);
      check("act1_cnt", frame_cnt, 0);

      // Hit between ticks lands on the next tick
      pulse_hit();
      check("hit_pend_hold", state, 5);
      tick(1'b0);
      check("hit_st", state, 3);
      check("hit_att", attacking, 0);
      check("hit_cnt", frame_cnt, 0);
      for (int i = 1; i <= 11; i++) tick(1'b0);
      check("stun_end_st", state, 3);
      check("stun_end_cnt", frame_cnt, 11);
      tick(1'b0);
      check("stun_exit", state, 0);
      tick(1'b0);
      check("held_no_retrig", state, 0);

      // Hit at stun tick 8 restarts the stun
      pulse_hit();
      tick(1'b0);
      check("hit2_st", state, 3);
      for (int i = 1; i <= 8; i++) tick(1'b0);
      check("stun8_cnt", frame_cnt, 8);
      pulse_hit();
      tick(1'b0);
      check("restun_st", state, 3);
      check("restun_cnt", frame_cnt, 0);
      for (int i = 1; i <= 11; i++) tick(1'b0);
      check("restun_late", state, 3);
      tick(1'b0);
      check("restun_exit", state, 0);
      btn_attack = 1'b0;

      // Both directions held plus attack glitches between ticks
      do_reset("both");
      btn_left  = 1'b1;
      btn_right = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick(1'b0);
         check("both_st", state, 0);
         check("both_x", x_pos, 100);
         @(negedge clk);
         btn_attack = 1'b1;
         @(negedge clk);
         btn_attack = 1'b0;
      end
      btn_attack = 1'b1;
      repeat (4) @(negedge clk);
      check("no_tick_st", state, 0);
      tick(1'b0);
      check("both_atk_st", state, 4);
      check("both_atk_x", x_pos, 100);

      // Same-tick hit and attack edge: hit wins
      do_reset("same");
      btn_left   = 1'b0;
      btn_right  = 1'b0;
      btn_attack = 1'b0;
      tick(1'b0);
      btn_attack = 1'b1;
      tick(1'b1);
      check("same_tick_st", state, 3);
      check("same_tick_att", attacking, 0);
      btn_attack = 1'b0;

      // Pending hit is discarded by reset
      do_reset("pre");
      pulse_hit();
      do_reset("disc");
      tick(1'b0);
      check("disc_st", state, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
